frame_buffer_read_arbiter: RTL and testbench

//  Shares the single read port of the double-banked image buffer RAM between two

---
 rtl/frame_buffer_read_arbiter.sv | 147 ++++++++++++++
 tb/tb_frame_buffer_read_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_read_arbiter.sv
// Round-robin owner of the image buffer RAM read port: grants one frame consumer at a time,
// pins the read bank for the grant, maps bank-relative addresses to physical ones and flags tearing.
module frame_buffer_read_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int BANK_OFFSET = 3072,
  parameter int TIMEOUT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              rel0,
  input  logic [ADDR_W-1:0] laddr0,
  input  logic              req1,
  input  logic              rel1,
  input  logic [ADDR_W-1:0] laddr1,
  input  logic              wr_bank,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] addr_out,
  output logic              rd_bank,
  output logic              overrun,
  output logic              addr_err,
  output logic              timeout
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [ADDR_W:0]  OFFSET_EXT = (ADDR_W + 1)'(BANK_OFFSET);

  state_t             state_q, state_d;
  logic               last_gnt_q, last_gnt_d;
  logic               rd_bank_q, rd_bank_d;
  logic               ovr_done_q, ovr_done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               overrun_q, overrun_d;
  logic               addr_err_q, addr_err_d;
  logic               timeout_q, timeout_d;

  logic               holder;
  logic               rel_holder;
  logic [ADDR_W:0]    laddr_ext;
  logic [ADDR_W:0]    bank_base;
  logic [ADDR_W:0]    phys_sum;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    rd_bank_d  = rd_bank_q;
    ovr_done_d = ovr_done_q;
    cnt_d      = cnt_q;
    addr_err_d = addr_err_q;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;
    addr_d     = '0;

    holder     = (state_q == GRANT1);
    rel_holder = holder ? rel1 : rel0;
    laddr_ext  = {1'b0, (holder ? laddr1 : laddr0)};
    bank_base  = rd_bank_q ? OFFSET_EXT : '0;
    phys_sum   = laddr_ext + bank_base;

    case (state_q)
      IDLE: begin
        // Under contention the requester that did not hold last wins; last_gnt resets to 1.
        if (req0 && (!req1 || last_gnt_q)) begin
          state_d    = GRANT0;
          last_gnt_d = 1'b0;
        end else if (req1) begin
          state_d    = GRANT1;
          last_gnt_d = 1'b1;
        end
        if (req0 || req1) begin
          rd_bank_d  = ~wr_bank;
          ovr_done_d = 1'b0;
          cnt_d      = '0;
        end
      end
      GRANT0, GRANT1: begin
        // Out-of-bank addresses (or a wrapped sum) are clamped to the bank base.
        if (laddr_ext >= OFFSET_EXT || phys_sum[ADDR_W]) begin
          addr_d     = bank_base[ADDR_W-1:0];
          addr_err_d = 1'b1;
        end else begin
          addr_d = phys_sum[ADDR_W-1:0];
        end
        if (wr_bank == rd_bank_q && !ovr_done_q) begin
          overrun_d  = 1'b1;
          ovr_done_d = 1'b1;
        end
        if (rel_holder) begin
          state_d = IDLE;
        end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    gnt0_d = (state_d == GRANT0);
    gnt1_d = (state_d == GRANT1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      rd_bank_q  <= 1'b0;
      ovr_done_q <= 1'b0;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      addr_q     <= '0;
      overrun_q  <= 1'b0;
      addr_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rd_bank_q  <= rd_bank_d;
      ovr_done_q <= ovr_done_d;
      cnt_q      <= cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      addr_q     <= addr_d;
      overrun_q  <= overrun_d;
      addr_err_q <= addr_err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign addr_out = addr_q;
  assign rd_bank  = rd_bank_q;
  assign overrun  = overrun_q;
  assign addr_err = addr_err_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_frame_buffer_read_arbiter.sv
// Scoreboard bench for frame_buffer_read_arbiter: a cycle model pushes expected outputs at each
// posedge, a monitor pops and compares them at the following negedge.
module tb_frame_buffer_read_arbiter;

  localparam int ADDR_W = 13;
  localparam int BOFF   = 3072;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst, req0, rel0, req1, rel1, wr_bank;
  logic [ADDR_W-1:0] laddr0, laddr1;
  logic              gnt0, gnt1, rd_bank, overrun, addr_err, timeout;
  logic [ADDR_W-1:0] addr_out;

  frame_buffer_read_arbiter #(.ADDR_W(ADDR_W), .BANK_OFFSET(BOFF), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rel0(rel0), .laddr0(laddr0),
    .req1(req1), .rel1(rel1), .laddr1(laddr1),
    .wr_bank(wr_bank),
    .gnt0(gnt0), .gnt1(gnt1), .addr_out(addr_out), .rd_bank(rd_bank),
    .overrun(overrun), .addr_err(addr_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              gnt0;
    logic              gnt1;
    logic [ADDR_W-1:0] addr;
    logic              rd_bank;
    logic              overrun;
    logic              addr_err;
    logic              timeout;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: owner is -1 when the port is free, else the holding requester.
  int owner = -1;
  int last  = 1;
  int rdb   = 0;
  int err   = 0;
  int torn  = 0;
  int held  = 0;

  always @(posedge clk) begin : model
    exp_t e;
    int   la, base, win;
    e = '0;
    if (rst) begin
      owner = -1; last = 1; rdb = 0; err = 0; torn = 0; held = 0;
    end else begin
      if (owner >= 0) begin
        la   = (owner == 1) ? int'(laddr1) : int'(laddr0);
        base = rdb ? BOFF : 0;
        if (la >= BOFF) begin
          e.addr = ADDR_W'(base);
          err    = 1;
        end else begin
          e.addr = ADDR_W'(la + base);
        end
        if (int'(wr_bank) == rdb && torn == 0) begin
          e.overrun = 1'b1;
          torn      = 1;
        end
        held++;
        if ((owner == 0 && rel0) || (owner == 1 && rel1)) begin
          owner = -1;
        end else if (held == TMO) begin
          owner     = -1;
          e.timeout = 1'b1;
        end
      end else begin
        win = -1;
        if (req0 && req1) win = (last == 0) ? 1 : 0;
        else if (req0)    win = 0;
        else if (req1)    win = 1;
        if (win >= 0) begin
          owner = win; last = win; rdb = wr_bank ? 0 : 1; torn = 0; held = 0;
        end
      end
      e.gnt0     = (owner == 0);
      e.gnt1     = (owner == 1);
      e.rd_bank  = (rdb != 0);
      e.addr_err = (err != 0);
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at vector %0d: got %0d, expected %0d", name, vectors, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      chk("gnt0",     int'(gnt0),     int'(e.gnt0));
      chk("gnt1",     int'(gnt1),     int'(e.gnt1));
      chk("addr_out", int'(addr_out), int'(e.addr));
      chk("rd_bank",  int'(rd_bank),  int'(e.rd_bank));
      chk("overrun",  int'(overrun),  int'(e.overrun));
      chk("addr_err", int'(addr_err), int'(e.addr_err));
      chk("timeout",  int'(timeout),  int'(e.timeout));
      chk("gnt_excl", int'(gnt0 & gnt1), 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic quiet();
    req0 = 1'b0; req1 = 1'b0; rel0 = 1'b0; rel1 = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic pulse_rel(input int which);
    if (which == 0) rel0 = 1'b1; else rel1 = 1'b1;
    cyc(1);
    rel0 = 1'b0; rel1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_bank = 1'b0; laddr0 = '0; laddr1 = '0;
    quiet();
    cyc(3);

    // Basic grant, bank latch and address translation.
    do_reset();
    wr_bank = 1'b0; laddr0 = 13'd5; req0 = 1'b1;
    cyc(3);
    req0 = 1'b0; laddr0 = 13'd3071;
    cyc(2);
    pulse_rel(0);
    cyc(2);

    // Contention alternates, with the mandatory idle gap.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; laddr1 = 13'd100;
    cyc(2);
    req0 = 1'b0;
    cyc(1);
    pulse_rel(0);
    cyc(3);
    req1 = 1'b0;
    pulse_rel(1);
    req0 = 1'b1; req1 = 1'b1;
    cyc(2);
    quiet();
    pulse_rel(0);
    cyc(3);
    pulse_rel(1);
    cyc(2);

    // Tearing: one overrun pulse per grant, rd_bank held.
    do_reset();
    wr_bank = 1'b0; req1 = 1'b1;
    cyc(2);
    req1 = 1'b0;
    wr_bank = 1'b1; cyc(3);
    wr_bank = 1'b0; cyc(2);
    wr_bank = 1'b1; cyc(3);
    pulse_rel(1);
    cyc(2);

    // Out-of-bank address sets the sticky error.
    wr_bank = 1'b0; laddr0 = 13'd3072; req0 = 1'b1;
    cyc(3);
    req0 = 1'b0; laddr0 = 13'd7;
    cyc(2);
    pulse_rel(0);
    cyc(4);

    // Watchdog revokes a grant that is never released.
    do_reset();
    req1 = 1'b1;
    cyc(14);
    req0 = 1'b1;
    cyc(8);
    req0 = 1'b0;
    pulse_rel(0);
    cyc(3);
    req1 = 1'b0;
    pulse_rel(1);
    cyc(2);

    // Reset in the middle of a grant, then normal service.
    req0 = 1'b1; laddr0 = 13'd3072;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    laddr0 = 13'd9;
    cyc(3);
    req0 = 1'b0;
    pulse_rel(0);
    cyc(2);

    // Randomised traffic with occasional resets, bad addresses and bank flips.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      req0    = ($urandom_range(0, 2) != 0);
      req1    = ($urandom_range(0, 2) != 0);
      rel0    = ($urandom_range(0, 4) == 0);
      rel1    = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) wr_bank = ~wr_bank;
      laddr0  = ($urandom_range(0, 49) == 0) ? ADDR_W'($urandom_range(3072, 8191))
                                              : ADDR_W'($urandom_range(0, 3071));
      laddr1  = ($urandom_range(0, 49) == 0) ? ADDR_W'($urandom_range(3072, 8191))
                                              : ADDR_W'($urandom_range(0, 3071));
      cyc(1);
    end
    rst = 1'b0;
    quiet();
    cyc(3);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
